antares_fetch_unit: RTL and testbench
=====================================

# antares_fetch_unit

Instruction-fetch stage of the Antares pipeline: owns the PC, runs the instruction-memory read handshake, and produces the IF-side fields (instruction, PC+4, exception PC, BDS flag, stall, flush) consumed by the IF->ID pipeline register. Holds one returned instruction when ID is stalled. Tracks delay-slot/branch-target state when the BDS fetch is slow. Aborts in-flight fetches cleanly on exception redirect.

## Interface
- RESET_VECTOR, 32'hBFC0_0000, first fetch address after reset
- clk  in  1  main clock
- rst  in  1  main reset; asynchronous, active-high
- imem_address  out  32  fetch address (= pc)
- imem_read  out  1  read request; held until imem_ready
- imem_ready  in  1  one-cycle pulse: imem_data valid, transaction done
- imem_data  in  32  returned instruction
- id_stall  in  1  ID stalled (from hazard unit)
- id_is_ctrl  in  1  ID holds a branch/jump (taken or not)
- id_branch_taken  in  1  ID control transfer is taken
- id_branch_target  in  32  its target
- exc_redirect  in  1  one-cycle pulse: redirect to exc_vector
- exc_vector  in  32  exception handler address
- if_instruction  out  32  instruction to IF/ID
- if_pc_add4  out  32  pc + 4
- if_exception_pc  out  32  pc
- if_is_bds  out  1  delivered instruction is a delay slot
- if_stall  out  1  no valid instruction this cycle
- if_flush  out  1  delivered/current instruction must be killed

## Operation
- State: pc, FSM {FETCH, DISCARD}, buf_valid/buf_data, bds_pending, br_pending/br_target, exc_target.
- imem_read = ~rst & ~buf_valid (in FETCH or DISCARD); imem_address = pc, stable for the whole transaction.
- if_valid = (state==FETCH & imem_ready) | buf_valid; if_instruction = buf_valid ? buf_data : imem_data.
- accept = if_valid & ~id_stall & ~exc_redirect.
- if_stall = ~if_valid | state==DISCARD. if_flush = exc_redirect | state==DISCARD.
- if_is_bds = id_is_ctrl | bds_pending.
- FETCH & imem_ready & id_stall & ~exc_redirect: buf_data<=imem_data, buf_valid<=1.
- On accept: buf_valid<=0; pc <= branch target if (id_branch_taken | br_pending) else pc+4 (br_target if br_pending, else id_branch_target); clear bds_pending, br_pending.
- id_is_ctrl & ~id_stall & ~accept: bds_pending<=1; if id_branch_taken also br_pending<=1, br_target<=id_branch_target.
- exc_redirect, highest priority: clears buf_valid, bds_pending, br_pending. If read outstanding without imem_ready this cycle: exc_target<=exc_vector, -> DISCARD. Else pc<=exc_vector, stay FETCH.
- DISCARD: keep request; on imem_ready drop data, pc<=exc_target, -> FETCH. A new exc_redirect in DISCARD overwrites exc_target.
- Addresses wrap modulo 2^32; pc+4 of 32'hFFFF_FFFC is 0.

## Timing
- Reset (async): pc=RESET_VECTOR, FETCH, all flags 0; imem_read=0, if_stall=1, if_flush=0, if_is_bds=0, if_pc_add4=RESET_VECTOR+4 while rst high.
- First request the cycle after rst deasserts.
- Zero-wait memory (ready in request cycle): one instruction per cycle, new pc next cycle.
- Buffered instruction delivered the first cycle id_stall=0; next request starts the cycle after accept.
- Reset mid-transaction abandons it; memory side must tolerate.

## Structure
- Shared package antares_defines: FSM state encodings, default RESET_VECTOR.
- Sub-module antares_fetch_buffer: one-entry instruction holding register (load/clear/valid).

## Test plan
- Reset, ready every cycle -> addresses BFC00000, BFC00004, BFC00008; if_pc_add4 = address+4, if_stall=0.
- imem_ready delayed 3 cycles -> if_stall=1 three cycles, imem_address constant, then instruction delivered.
- ready with id_stall=1, data 32'h2408_0001 -> imem_read drops, held 2 cycles, delivered when id_stall=0, next address only after.
- id_is_ctrl+taken target 32'h8000_0100 while BDS read waits 2 cycles -> BDS delivered with if_is_bds=1, next address 32'h8000_0100.
- exc_redirect vector 32'h8000_0180 mid-read with branch pending -> DISCARD, if_flush=1, data dropped, next address 32'h8000_0180, branch lost.
- rst asserted mid-read -> imem_read 0 immediately, restart at RESET_VECTOR.

Source files
------------

// File: rtl/antares_defines.sv
// Shared definitions for the Antares pipeline: fetch FSM encodings and reset vector.
package antares_defines;

    typedef enum logic [0:0] {
        StFetch   = 1'b0,
        StDiscard = 1'b1
    } fetch_state_e;

    localparam logic [31:0] ResetVectorDefault = 32'hBFC0_0000;

    function automatic logic [31:0] pc_add4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/antares_fetch_unit_if.sv
// Instruction-memory read port: the fetch unit is master, the memory is slave.
interface antares_fetch_unit_if;
    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_ready;
    logic [31:0] imem_data;

    modport master (
        output imem_address,
        output imem_read,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_address,
        input  imem_read,
        output imem_ready,
        output imem_data
    );
endinterface

// File: rtl/antares_fetch_buffer.sv
// One-entry holding register for an instruction returned while ID is stalled.
module antares_fetch_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    output logic        valid_o,
    output logic [31:0] data_o
);

    logic        valid_q;
    logic [31:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= 32'h0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/antares_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem read handshake, tracks
// delay-slot / pending-branch state and aborts in-flight reads on exception redirect.
module antares_fetch_unit
    import antares_defines::*;
#(
    parameter logic [31:0] RESET_VECTOR = ResetVectorDefault
) (
    input  logic                        clk,
    input  logic                        rst,
    antares_fetch_unit_if.master        imem,
    input  logic                        id_stall,
    input  logic                        id_is_ctrl,
    input  logic                        id_branch_taken,
    input  logic [31:0]                 id_branch_target,
    input  logic                        exc_redirect,
    input  logic [31:0]                 exc_vector,
    output logic [31:0]                 if_instruction,
    output logic [31:0]                 if_pc_add4,
    output logic [31:0]                 if_exception_pc,
    output logic                        if_is_bds,
    output logic                        if_stall,
    output logic                        if_flush
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         bds_pending_q;
    logic         br_pending_q;
    logic [31:0]  br_target_q;
    logic [31:0]  exc_target_q;

    logic         buf_valid;
    logic [31:0]  buf_data;
    logic         buf_load;
    logic         buf_clear;
    logic         if_valid;
    logic         accept;
    logic         take_branch;
    logic [31:0]  branch_pc;

    assign imem.imem_read    = ~rst & ~buf_valid;
    assign imem.imem_address = pc_q;

    assign if_valid       = ((state_q == StFetch) & imem.imem_ready) | buf_valid;
    assign accept         = if_valid & ~id_stall & ~exc_redirect;
    assign if_instruction = buf_valid ? buf_data : imem.imem_data;
    assign if_pc_add4     = pc_add4(pc_q);
    assign if_exception_pc = pc_q;
    assign if_stall       = ~if_valid | (state_q == StDiscard);
    assign if_flush       = exc_redirect | (state_q == StDiscard);
    assign if_is_bds      = id_is_ctrl | bds_pending_q;

    // A branch resolved while the delay slot was still in flight wins over ID's current view.
    assign take_branch = id_branch_taken | br_pending_q;
    assign branch_pc   = br_pending_q ? br_target_q : id_branch_target;

    assign buf_load  = (state_q == StFetch) & imem.imem_ready & id_stall & ~exc_redirect &
                       ~buf_valid;
    assign buf_clear = accept | exc_redirect;

    antares_fetch_buffer u_fetch_buffer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .data_i  (imem.imem_data),
        .valid_o (buf_valid),
        .data_o  (buf_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StFetch;
            pc_q          <= RESET_VECTOR;
            bds_pending_q <= 1'b0;
            br_pending_q  <= 1'b0;
            br_target_q   <= 32'h0;
            exc_target_q  <= 32'h0;
        end else if (exc_redirect) begin
            bds_pending_q <= 1'b0;
            br_pending_q  <= 1'b0;
            // An outstanding read must complete before the new address can be issued.
            if (imem.imem_read && !imem.imem_ready) begin
                exc_target_q <= exc_vector;
                state_q      <= StDiscard;
            end else begin
                pc_q    <= exc_vector;
                state_q <= StFetch;
            end
        end else if (state_q == StDiscard) begin
            if (imem.imem_ready) begin
                pc_q    <= exc_target_q;
                state_q <= StFetch;
            end
        end else if (accept) begin
            pc_q          <= take_branch ? branch_pc : pc_add4(pc_q);
            bds_pending_q <= 1'b0;
            br_pending_q  <= 1'b0;
        end else if (id_is_ctrl && !id_stall) begin
            bds_pending_q <= 1'b1;
            if (id_branch_taken) begin
                br_pending_q <= 1'b1;
                br_target_q  <= id_branch_target;
            end
        end
    end

endmodule

// File: tb/tb_antares_fetch_unit.sv
// Scoreboard bench for antares_fetch_unit: stimulus pushes expected deliveries,
// a negedge monitor pops and compares whenever an instruction is accepted by ID.
module tb_antares_fetch_unit;

    logic        clk;
    logic        rst;
    logic        id_stall;
    logic        id_is_ctrl;
    logic        id_branch_taken;
    logic [31:0] id_branch_target;
    logic        exc_redirect;
    logic [31:0] exc_vector;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_add4;
    logic [31:0] if_exception_pc;
    logic        if_is_bds;
    logic        if_stall;
    logic        if_flush;

    antares_fetch_unit_if imem_if ();

    antares_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem             (imem_if),
        .id_stall         (id_stall),
        .id_is_ctrl       (id_is_ctrl),
        .id_branch_taken  (id_branch_taken),
        .id_branch_target (id_branch_target),
        .exc_redirect     (exc_redirect),
        .exc_vector       (exc_vector),
        .if_instruction   (if_instruction),
        .if_pc_add4       (if_pc_add4),
        .if_exception_pc  (if_exception_pc),
        .if_is_bds        (if_is_bds),
        .if_stall         (if_stall),
        .if_flush         (if_flush)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bds;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_deliver(input logic [31:0] instr, input logic [31:0] pc,
                                  input logic bds);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.bds   = bds;
        exp_q.push_back(e);
    endtask

    // Monitor: an instruction is consumed by ID when valid, not stalled, not flushed.
    always @(negedge clk) begin
        if (!rst && !if_stall && !id_stall && !exc_redirect) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", if_instruction, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("deliver_instr", if_instruction, e.instr);
                check("deliver_pc", if_exception_pc, e.pc);
                check("deliver_pc_add4", if_pc_add4, e.pc + 32'd4);
                check("deliver_bds", {31'h0, if_is_bds}, {31'h0, e.bds});
            end
        end
    end

    initial begin
        rst              = 1'b1;
        id_stall         = 1'b0;
        id_is_ctrl       = 1'b0;
        id_branch_taken  = 1'b0;
        id_branch_target = 32'h0;
        exc_redirect     = 1'b0;
        exc_vector       = 32'h0;
        imem_if.imem_ready = 1'b0;
        imem_if.imem_data  = 32'h0;
        #3;
        check("rst_imem_read", {31'h0, imem_if.imem_read}, 32'h0);
        check("rst_if_stall", {31'h0, if_stall}, 32'h1);
        check("rst_if_flush", {31'h0, if_flush}, 32'h0);
        check("rst_if_is_bds", {31'h0, if_is_bds}, 32'h0);
        check("rst_pc_add4", if_pc_add4, 32'hBFC0_0004);
        check("rst_address", imem_if.imem_address, 32'hBFC0_0000);
        next();
        next();
        rst = 1'b0;

        // Zero-wait memory: one instruction per cycle.
        for (int i = 0; i < 3; i++) begin
            imem_if.imem_ready = 1'b1;
            imem_if.imem_data  = 32'h1000_0000 + i;
            #1;
            check("zw_address", imem_if.imem_address, 32'hBFC0_0000 + 4 * i);
            check("zw_read", {31'h0, imem_if.imem_read}, 32'h1);
            check("zw_stall", {31'h0, if_stall}, 32'h0);
            expect_deliver(32'h1000_0000 + i, 32'hBFC0_0000 + 4 * i, 1'b0);
            next();
        end

        // Three wait cycles.
        imem_if.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wait_stall", {31'h0, if_stall}, 32'h1);
            check("wait_address", imem_if.imem_address, 32'hBFC0_000C);
            next();
        end
        imem_if.imem_ready = 1'b1;
        imem_if.imem_data  = 32'h3C08_BEEF;
        expect_deliver(32'h3C08_BEEF, 32'hBFC0_000C, 1'b0);
        next();

        // ID stalled when data returns: buffer it, drop the request.
        id_stall           = 1'b1;
        imem_if.imem_data  = 32'h2408_0001;
        expect_deliver(32'h2408_0001, 32'hBFC0_0010, 1'b0);
        next();
        imem_if.imem_ready = 1'b0;
        imem_if.imem_data  = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("hold_read", {31'h0, imem_if.imem_read}, 32'h0);
            check("hold_address", imem_if.imem_address, 32'hBFC0_0010);
            check("hold_instr", if_instruction, 32'h2408_0001);
            next();
        end
        id_stall = 1'b0;
        #1;
        check("release_read", {31'h0, imem_if.imem_read}, 32'h0);
        next();
        check("after_release_read", {31'h0, imem_if.imem_read}, 32'h1);
        check("after_release_addr", imem_if.imem_address, 32'hBFC0_0014);

        // Taken branch in ID while its delay slot read waits two cycles.
        id_is_ctrl       = 1'b1;
        id_branch_taken  = 1'b1;
        id_branch_target = 32'h8000_0100;
        #1;
        check("bds_flag_ctrl", {31'h0, if_is_bds}, 32'h1);
        next();
        id_is_ctrl       = 1'b0;
        id_branch_taken  = 1'b0;
        id_branch_target = 32'h0;
        #1;
        check("bds_flag_pending", {31'h0, if_is_bds}, 32'h1);
        next();
        imem_if.imem_ready = 1'b1;
        imem_if.imem_data  = 32'h2529_0004;
        expect_deliver(32'h2529_0004, 32'hBFC0_0014, 1'b1);
        next();
        imem_if.imem_ready = 1'b0;
        #1;
        check("branch_target_addr", imem_if.imem_address, 32'h8000_0100);
        check("bds_cleared", {31'h0, if_is_bds}, 32'h0);

        // Exception mid-read with a branch pending: discard, redirect, branch lost.
        id_is_ctrl       = 1'b1;
        id_branch_taken  = 1'b1;
        id_branch_target = 32'h8000_0200;
        next();
        id_is_ctrl       = 1'b0;
        id_branch_taken  = 1'b0;
        exc_redirect     = 1'b1;
        exc_vector       = 32'h8000_0180;
        #1;
        check("exc_flush", {31'h0, if_flush}, 32'h1);
        next();
        exc_redirect = 1'b0;
        exc_vector   = 32'h0;
        #1;
        check("discard_flush", {31'h0, if_flush}, 32'h1);
        check("discard_stall", {31'h0, if_stall}, 32'h1);
        check("discard_read", {31'h0, imem_if.imem_read}, 32'h1);
        check("discard_address", imem_if.imem_address, 32'h8000_0100);
        next();
        imem_if.imem_ready = 1'b1;
        imem_if.imem_data  = 32'hDEAD_BEEF;
        #1;
        check("discard_drop_flush", {31'h0, if_flush}, 32'h1);
        next();
        imem_if.imem_ready = 1'b0;
        #1;
        check("exc_vector_addr", imem_if.imem_address, 32'h8000_0180);
        check("exc_branch_lost_bds", {31'h0, if_is_bds}, 32'h0);
        check("exc_no_flush", {31'h0, if_flush}, 32'h0);
        next();
        imem_if.imem_ready = 1'b1;
        imem_if.imem_data  = 32'h4080_6000;
        expect_deliver(32'h4080_6000, 32'h8000_0180, 1'b0);
        next();
        #1;
        check("after_exc_addr", imem_if.imem_address, 32'h8000_0184);

        // Redirect coinciding with ready: direct jump, then PC wraps past 2^32.
        exc_redirect       = 1'b1;
        exc_vector         = 32'hFFFF_FFFC;
        imem_if.imem_data  = 32'h0BAD_0BAD;
        next();
        exc_redirect       = 1'b0;
        imem_if.imem_data  = 32'h2442_FFFF;
        #1;
        check("wrap_address", imem_if.imem_address, 32'hFFFF_FFFC);
        check("wrap_pc_add4", if_pc_add4, 32'h0);
        expect_deliver(32'h2442_FFFF, 32'hFFFF_FFFC, 1'b0);
        next();
        imem_if.imem_ready = 1'b0;
        #1;
        check("wrap_next_addr", imem_if.imem_address, 32'h0);
        next();

        // Reset in the middle of an outstanding read.
        rst = 1'b1;
        #1;
        check("midrst_read", {31'h0, imem_if.imem_read}, 32'h0);
        check("midrst_address", imem_if.imem_address, 32'hBFC0_0000);
        check("midrst_stall", {31'h0, if_stall}, 32'h1);
        next();
        rst = 1'b0;
        imem_if.imem_ready = 1'b1;
        imem_if.imem_data  = 32'h3421_0001;
        expect_deliver(32'h3421_0001, 32'hBFC0_0000, 1'b0);
        next();
        imem_if.imem_ready = 1'b0;
        #1;
        check("restart_addr", imem_if.imem_address, 32'hBFC0_0004);
        next();
        next();

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
